// File: rtl/reg_status_table.sv
// Tomasulo register status table: value + producer tag per register, two bypassed reads,
// one rename and one CDB snoop per cycle. Optional flush port under REG_STATUS_FLUSH_EN.
module reg_status_table #(
    parameter int unsigned      NUM_REGS    = 32,
    parameter int unsigned      REG_AW      = 5,
    parameter int unsigned      DATA_W      = 32,
    parameter int unsigned      TAG_W       = 5,
    parameter logic [TAG_W-1:0] INVALID_TAG = '1,
    parameter bit               HARDWIRE_R0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_enable,
    input  logic [REG_AW-1:0] in_reg_1,
    input  logic [REG_AW-1:0] in_reg_2,
    input  logic              in_bank_enable,
    input  logic [REG_AW-1:0] in_bank_reg,
    input  logic [TAG_W-1:0]  in_bank_tag,
    input  logic              in_CDB_broadcast,
    input  logic [TAG_W-1:0]  in_CDB_tag,
    input  logic [DATA_W-1:0] in_CDB_val,
`ifdef REG_STATUS_FLUSH_EN
    input  logic              in_flush,
`endif
    output logic              out_enable,
    output logic [DATA_W-1:0] out_val_1,
    output logic [DATA_W-1:0] out_val_2,
    output logic [TAG_W-1:0]  out_tag_1,
    output logic [TAG_W-1:0]  out_tag_2,
    output logic [REG_AW:0]   out_pending
);

    logic [TAG_W-1:0]  tag_q [NUM_REGS];
    logic [TAG_W-1:0]  tag_d [NUM_REGS];
    logic [DATA_W-1:0] val_q [NUM_REGS];
    logic [DATA_W-1:0] val_d [NUM_REGS];
    logic [REG_AW:0]   pending_d;
    logic              cdb_live;
    logic              bank_live;

    logic [DATA_W-1:0] rd_val_1, rd_val_2;
    logic [TAG_W-1:0]  rd_tag_1, rd_tag_2;

    // A broadcast or rename carrying INVALID_TAG is treated as absent.
    assign cdb_live  = in_CDB_broadcast && (in_CDB_tag != INVALID_TAG);
    assign bank_live = in_bank_enable && (in_bank_tag != INVALID_TAG);

    always_comb begin
        pending_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            tag_d[i] = tag_q[i];
            val_d[i] = val_q[i];
            if (cdb_live && (tag_q[i] == in_CDB_tag)) begin
                val_d[i] = in_CDB_val;
                tag_d[i] = INVALID_TAG;
            end
            if (bank_live && (in_bank_reg == REG_AW'(i))) begin
                tag_d[i] = in_bank_tag;
            end
`ifdef REG_STATUS_FLUSH_EN
            if (in_flush) begin
                tag_d[i] = INVALID_TAG;
            end
`endif
            if (HARDWIRE_R0 && (i == 0)) begin
                tag_d[i] = INVALID_TAG;
                val_d[i] = '0;
            end
            if (tag_d[i] != INVALID_TAG) begin
                pending_d = pending_d + (REG_AW+1)'(1);
            end
        end
    end

    function automatic logic [TAG_W-1:0] lookup_tag(input logic [REG_AW-1:0] idx);
        logic [TAG_W-1:0] t;
        t = INVALID_TAG;
        if ((32'(idx) < NUM_REGS) && !(HARDWIRE_R0 && (idx == '0))) begin
            if (!(cdb_live && (tag_q[idx] == in_CDB_tag))) begin
                t = tag_q[idx];
            end
        end
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] lookup_val(input logic [REG_AW-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if ((32'(idx) < NUM_REGS) && !(HARDWIRE_R0 && (idx == '0))) begin
            if (cdb_live && (tag_q[idx] == in_CDB_tag)) begin
                v = in_CDB_val;
            end else begin
                v = val_q[idx];
            end
        end
        return v;
    endfunction

    // Reads see pre-rename state with same-cycle CDB bypass.
    always_comb begin
        rd_val_1 = lookup_val(in_reg_1);
        rd_val_2 = lookup_val(in_reg_2);
        rd_tag_1 = lookup_tag(in_reg_1);
        rd_tag_2 = lookup_tag(in_reg_2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                tag_q[i] <= INVALID_TAG;
                val_q[i] <= '0;
            end
            out_enable  <= 1'b0;
            out_val_1   <= '0;
            out_val_2   <= '0;
            out_tag_1   <= INVALID_TAG;
            out_tag_2   <= INVALID_TAG;
            out_pending <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                tag_q[i] <= tag_d[i];
                val_q[i] <= val_d[i];
            end
            out_enable  <= in_enable;
            out_pending <= pending_d;
            if (in_enable) begin
                out_val_1 <= rd_val_1;
                out_val_2 <= rd_val_2;
                out_tag_1 <= rd_tag_1;
                out_tag_2 <= rd_tag_2;
            end
        end
    end

endmodule

// File: tb/tb_reg_status_table.sv
// Randomised self-checking bench for reg_status_table against a behavioural table model.
// Exercises the flush port when REG_STATUS_FLUSH_EN is defined.
module tb_reg_status_table;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int TW  = 5;
    localparam logic [TW-1:0] INV = 5'd31;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_enable = 1'b0;
    logic [AW-1:0] in_reg_1 = '0, in_reg_2 = '0;
    logic          in_bank_enable = 1'b0;
    logic [AW-1:0] in_bank_reg = '0;
    logic [TW-1:0] in_bank_tag = '0;
    logic          in_CDB_broadcast = 1'b0;
    logic [TW-1:0] in_CDB_tag = '0;
    logic [DW-1:0] in_CDB_val = '0;
    logic          in_flush = 1'b0;
    logic          out_enable;
    logic [DW-1:0] out_val_1, out_val_2;
    logic [TW-1:0] out_tag_1, out_tag_2;
    logic [AW:0]   out_pending;

    reg_status_table dut (
        .clk              (clk),
        .rst              (rst),
        .in_enable        (in_enable),
        .in_reg_1         (in_reg_1),
        .in_reg_2         (in_reg_2),
        .in_bank_enable   (in_bank_enable),
        .in_bank_reg      (in_bank_reg),
        .in_bank_tag      (in_bank_tag),
        .in_CDB_broadcast (in_CDB_broadcast),
        .in_CDB_tag       (in_CDB_tag),
        .in_CDB_val       (in_CDB_val),
`ifdef REG_STATUS_FLUSH_EN
        .in_flush         (in_flush),
`endif
        .out_enable       (out_enable),
        .out_val_1        (out_val_1),
        .out_val_2        (out_val_2),
        .out_tag_1        (out_tag_1),
        .out_tag_2        (out_tag_2),
        .out_pending      (out_pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit flush_on;

    // Model: architectural table plus expected registered outputs
    logic [TW-1:0] m_tag [NR];
    logic [DW-1:0] m_val [NR];
    logic          e_en;
    logic [DW-1:0] e_val1, e_val2;
    logic [TW-1:0] e_tag1, e_tag2;
    int            e_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_tag[r] = INV;
            m_val[r] = '0;
        end
        e_en = 1'b0; e_val1 = '0; e_val2 = '0; e_tag1 = INV; e_tag2 = INV; e_pend = 0;
    endtask

    function automatic logic cdb_hits(input logic [TW-1:0] t);
        return in_CDB_broadcast && in_CDB_tag != INV && t == in_CDB_tag;
    endfunction

    task automatic model_read(input int idx, output logic [DW-1:0] v, output logic [TW-1:0] t);
        if (idx >= NR || idx == 0) begin
            v = '0; t = INV;
        end else if (cdb_hits(m_tag[idx])) begin
            v = in_CDB_val; t = INV;
        end else begin
            v = m_val[idx]; t = m_tag[idx];
        end
    endtask

    // Apply current inputs to the model across one rising edge.
    task automatic cycle();
        logic [TW-1:0] n_tag [NR];
        logic [DW-1:0] n_val [NR];
        logic [DW-1:0] v1, v2;
        logic [TW-1:0] t1, t2;
        int cnt;
        bit fl;
`ifdef REG_STATUS_FLUSH_EN
        fl = in_flush;
`else
        fl = 1'b0;
`endif
        model_read(int'(in_reg_1), v1, t1);
        model_read(int'(in_reg_2), v2, t2);
        cnt = 0;
        for (int r = 0; r < NR; r++) begin
            n_tag[r] = m_tag[r];
            n_val[r] = m_val[r];
            if (cdb_hits(m_tag[r])) begin
                n_val[r] = in_CDB_val;
                n_tag[r] = INV;
            end
            if (in_bank_enable && in_bank_tag != INV && int'(in_bank_reg) == r) n_tag[r] = in_bank_tag;
            if (fl) n_tag[r] = INV;
            if (r == 0) begin
                n_tag[r] = INV;
                n_val[r] = '0;
            end
            if (n_tag[r] != INV) cnt++;
        end
        @(posedge clk);
        for (int r = 0; r < NR; r++) begin
            m_tag[r] = n_tag[r];
            m_val[r] = n_val[r];
        end
        e_en = in_enable;
        e_pend = cnt;
        if (in_enable) begin
            e_val1 = v1; e_val2 = v2; e_tag1 = t1; e_tag2 = t2;
        end
        #1;
    endtask

    task automatic idle();
        in_enable = 1'b0; in_bank_enable = 1'b0; in_CDB_broadcast = 1'b0; in_flush = 1'b0;
    endtask

    task automatic rd(input int a, input int b);
        in_enable = 1'b1; in_reg_1 = AW'(a); in_reg_2 = AW'(b);
    endtask

    task automatic ren(input int r, input int t);
        in_bank_enable = 1'b1; in_bank_reg = AW'(r); in_bank_tag = TW'(t);
    endtask

    task automatic cdb(input int t, input logic [DW-1:0] v);
        in_CDB_broadcast = 1'b1; in_CDB_tag = TW'(t); in_CDB_val = v;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_en",   64'(out_enable),  64'(e_en));
            chk("cmp_val1", 64'(out_val_1),   64'(e_val1));
            chk("cmp_val2", 64'(out_val_2),   64'(e_val2));
            chk("cmp_tag1", 64'(out_tag_1),   64'(e_tag1));
            chk("cmp_tag2", 64'(out_tag_2),   64'(e_tag2));
            chk("cmp_pend", 64'(out_pending), 64'(e_pend));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},   64'(out_enable),  64'd0);
        chk({tag, "_val1"}, 64'(out_val_1),   64'd0);
        chk({tag, "_tag1"}, 64'(out_tag_1),   64'd31);
        chk({tag, "_tag2"}, 64'(out_tag_2),   64'd31);
        chk({tag, "_pend"}, 64'(out_pending), 64'd0);
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed pins of the model and DUT
        idle(); rd(4, 5); cycle();
        chk("rd45_en", 64'(out_enable), 64'd1);
        chk("rd45_val", 64'({out_val_1, out_val_2}), 64'd0);
        chk("rd45_tags", 64'({out_tag_1, out_tag_2}), 64'h3ff);
        chk("rd45_pend", 64'(out_pending), 64'd0);
        idle(); cycle();
        chk("idle_en", 64'(out_enable), 64'd0);

        idle(); ren(3, 2); cycle();
        idle(); rd(3, 0); cycle();
        chk("r3_tag", 64'(out_tag_1), 64'd2);
        chk("r3_pend", 64'(out_pending), 64'd1);

        idle(); cdb(2, 32'h1234); rd(3, 3); cycle();
        chk("byp_val", 64'(out_val_1), 64'h1234);
        chk("byp_tag", 64'(out_tag_1), 64'd31);
        idle(); rd(3, 0); cycle();
        chk("r3_after_val", 64'(out_val_1), 64'h1234);
        chk("r3_after_tag", 64'(out_tag_1), 64'd31);
        chk("r3_after_pend", 64'(out_pending), 64'd0);

        idle(); ren(7, 4); cycle();
        idle(); ren(7, 9); cycle();
        idle(); cdb(4, 32'd5); cycle();
        idle(); rd(7, 0); cycle();
        chk("waw_tag", 64'(out_tag_1), 64'd9);
        chk("waw_pend", 64'(out_pending), 64'd1);
        idle(); cdb(9, 32'd6); cycle();
        idle(); rd(7, 0); cycle();
        chk("waw_done", 64'({out_val_1, 3'b0, out_tag_1}), {32'd6, 8'd31});

        idle(); ren(1, 6); cycle();
        idle(); ren(1, 3); cdb(6, 32'd77); cycle();
        idle(); rd(1, 0); ren(1, 8); cycle();
        chk("ren_cdb_tag", 64'(out_tag_1), 64'd3);
        idle(); rd(1, 0); cycle();
        chk("ren_new_tag", 64'(out_tag_1), 64'd8);

        idle(); ren(0, 1); cycle();
        idle(); rd(0, 0); cdb(1, 32'hdead); cycle();
        chk("r0_val", 64'(out_val_1), 64'd0);
        chk("r0_tag", 64'(out_tag_1), 64'd31);

`ifdef REG_STATUS_FLUSH_EN
        idle(); ren(2, 10); cycle();
        idle(); ren(5, 11); cycle();
        idle(); in_flush = 1'b1; ren(6, 12); cycle();
        idle(); rd(2, 5); cycle();
        chk("flush_tags", 64'({out_tag_1, out_tag_2}), 64'h3ff);
        chk("flush_pend", 64'(out_pending), 64'd0);
`endif

        // Randomised traffic with colliding tags; one asynchronous reset midway
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                idle();
                rst = 1'b1;
                #1 check_reset_outputs("midrst");
                model_reset();
                @(negedge clk);
                #1 rst = 1'b0;
            end
            idle();
            in_enable = 1'($urandom_range(0, 1));
            in_reg_1 = AW'($urandom_range(0, 7) + (($urandom_range(0, 7) == 0) ? 8 : 0));
            in_reg_2 = AW'($urandom_range(0, 7));
            in_bank_enable = 1'($urandom_range(0, 1));
            in_bank_reg = AW'($urandom_range(0, 7));
            in_bank_tag = ($urandom_range(0, 9) == 0) ? INV : TW'($urandom_range(0, 7));
            in_CDB_broadcast = 1'($urandom_range(0, 1));
            in_CDB_tag = ($urandom_range(0, 9) == 0) ? INV : TW'($urandom_range(0, 7));
            in_CDB_val = $urandom;
            flush_on = ($urandom_range(0, 49) == 0);
            in_flush = flush_on;
            cycle();
        end

        idle(); cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
Name: reg_status_table

Overview:
Parametrised register status table for the Tomasulo issue stage. It holds a value plus producer tag per architectural register and serves two source-operand reads per issue. It accepts one destination rename per cycle from the reservation-station bank and snoops the CDB to retire tags. Fully synchronous to clk with registered outputs; it replaces the event-driven status table in the issue path.

Parameters:
NUM_REGS, 32, number of architectural registers
REG_AW, 5, register index width (clog2 NUM_REGS)
DATA_W, 32, register value width
TAG_W, 5, reservation-station tag width
INVALID_TAG, all-ones (TAG_W bits), tag meaning "value ready, no producer"
HARDWIRE_R0, 1, 1 = register 0 reads 0/INVALID_TAG and ignores rename and CDB writes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_enable  in  1  read request; sample in_reg_1/in_reg_2
in_reg_1  in  REG_AW  source register 1 index
in_reg_2  in  REG_AW  source register 2 index
in_bank_enable  in  1  rename request
in_bank_reg  in  REG_AW  destination register to rename
in_bank_tag  in  TAG_W  producer tag assigned to in_bank_reg
in_CDB_broadcast  in  1  CDB valid
in_CDB_tag  in  TAG_W  CDB producer tag
in_CDB_val  in  DATA_W  CDB result value
out_enable  out  1  one-cycle pulse, read results valid
out_val_1 / out_val_2  out  DATA_W  source values (meaningful only when tag == INVALID_TAG)
out_tag_1 / out_tag_2  out  TAG_W  source producer tags
out_pending  out  REG_AW+1  count of registers currently holding a non-INVALID tag

Behaviour:
- Reset (async, on rst high): all tags = INVALID_TAG, all values = 0, out_enable = 0, out_val_* = 0, out_tag_* = INVALID_TAG, out_pending = 0. Reset mid-operation drops every in-flight read and rename.
- Read: in_enable high at edge N -> out_enable = 1 and out_val/out_tag driven after edge N, held through the cycle ending at edge N+1. Latency is 1 cycle. Back-to-back reads allowed every cycle. out_enable = 0 otherwise; outputs hold their last value.
- Read vs CDB in the same cycle: bypass. If the stored tag of the read register equals in_CDB_tag with broadcast high, return in_CDB_val and INVALID_TAG.
- Read vs rename in the same cycle: the read returns the pre-rename state. Issue reads sources before renaming the destination, so an instruction such as r3 <- r3 + r1 sees the old producer of r3.
- Rename: in_bank_enable at edge sets tag[in_bank_reg] = in_bank_tag. The value is unchanged (don't-care while tagged). A rename with in_bank_tag == INVALID_TAG is a no-op.
- CDB: every register 0..NUM_REGS-1 whose tag == in_CDB_tag gets value = in_CDB_val and tag = INVALID_TAG. A broadcast of INVALID_TAG is ignored.
- Rename + CDB on the same register in the same cycle: rename wins (tag = in_bank_tag). CDB still updates all other matching registers.
- WAW: a later rename overwrites the tag. A CDB for the older tag then no longer matches and does not clear it.
- out_pending: registered; equals the popcount of non-INVALID tags after each edge. It updates the cycle after the causing event. Range 0..NUM_REGS, no wrap.
- HARDWIRE_R0 = 1: index 0 is never tagged or written and always reads value 0 with INVALID_TAG, including under bypass.
- Indices >= NUM_REGS (non-power-of-2 sizes): reads return 0/INVALID_TAG; renames are ignored.

Optional Feature:
REG_STATUS_FLUSH_EN: when defined, adds input in_flush (1 bit).
- in_flush high at edge: all tags become INVALID_TAG, values are retained, and out_pending becomes 0.
- Flush overrides a same-cycle rename.
- A same-cycle CDB still writes values to registers whose tag matched.
- A same-cycle read returns pre-flush state with CDB bypass.
When undefined: no port and no flush logic.

Test Plan:
- Reset then read r4,r5 -> next cycle out_enable = 1, values 0/0, tags 31/31, out_pending = 0.
- Rename r3 tag 2, then read r3 -> out_tag_1 = 2, out_pending = 1.
- CDB tag 2, value 0x1234, with a read of r3 in the same cycle -> out_val_1 = 0x1234, tag 31 (bypass). Later read of r3 also gives 0x1234/31, out_pending = 0.
- Rename r7 tag 4, then rename r7 tag 9, then CDB tag 4 value 5 -> r7 still tag 9, out_pending = 1. Then CDB tag 9 value 6 -> r7 = 6/31.
- Same cycle: rename r1 tag 3 and CDB matching r1's old tag 6 -> r1 tag = 3. Same cycle: read r1 with rename r1 tag 8 -> returns the old tag.
- Rename r0 tag 1 with HARDWIRE_R0 = 1 -> read r0 gives 0/31. With the flush macro: tag r2,r5, then in_flush -> out_pending = 0, both read 31.
